// File: rtl/bexkat_mem_pkg.sv
// Shared memory-subsystem definitions: SRAM bridge FSM states and the system address map.
// Used by sram_bridge (optional byte lanes via SRAM_BRIDGE_BYTE_LANE_EN) and its wait timer.
package bexkat_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_WR_SU = 3'd2,
        ST_WR_PW = 3'd3,
        ST_WR_HD = 3'd4,
        ST_DONE  = 3'd5
    } sram_state_t;

    localparam logic [31:0] SRAM_BASE    = 32'h0000_0000;
    localparam logic [31:0] SRAM_SIZE    = 32'h0008_0000;
    // Reserved for the address decoder that will sit in front of this bridge.
    localparam logic [31:0] MONITOR_BASE = 32'hFF00_0000;

    localparam int TIMER_W = 8;

    // Converts a phase length in cycles into the timer load value (counts down to zero).
    function automatic logic [TIMER_W-1:0] phase_load(input int cycles);
        return TIMER_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/sram_wait_timer.sv
// Loadable down-counter timing every SRAM phase; expired is high once the count reaches zero.
module sram_wait_timer
    import bexkat_mem_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] value,
    output logic               expired
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/sram_bridge.sv
// CPU-to-asynchronous-SRAM bridge with parameterised read/write timing and fault detection.
// Define SRAM_BRIDGE_BYTE_LANE_EN to add the cpu_be byte-lane input.
module sram_bridge
    import bexkat_mem_pkg::*;
#(
    parameter int ADDR_W   = 19,
    parameter int RD_WAIT  = 2,
    parameter int WR_SETUP = 1,
    parameter int WR_PULSE = 2,
    parameter int WR_HOLD  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [31:0]       cpu_addr,
    input  logic              cpu_write,
    input  logic [15:0]       cpu_wdata,
`ifdef SRAM_BRIDGE_BYTE_LANE_EN
    input  logic [1:0]        cpu_be,
`endif
    output logic [15:0]       cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_fault,
    output logic              cpu_busy,
    output logic [ADDR_W-2:0] sram_addr,
    input  logic [15:0]       sram_dq_in,
    output logic [15:0]       sram_dq_out,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

    sram_state_t        state;
    sram_state_t        next_state;
    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_value;
    logic               tmr_expired;
    logic               accept;
    logic               addr_bad;

    logic               ce_n_d;
    logic               oe_n_d;
    logic               we_n_d;
    logic               dq_oe_d;
    logic               ub_n_d;
    logic               lb_n_d;

    assign accept   = (state == ST_IDLE) && cpu_req;
    assign addr_bad = cpu_addr[0] || ((cpu_addr >> ADDR_W) != 32'd0);

`ifdef SRAM_BRIDGE_BYTE_LANE_EN
    logic [1:0] be_q;
    logic [1:0] be_next;
    assign be_next = accept ? cpu_be : be_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            be_q <= 2'b00;
        end else begin
            be_q <= be_next;
        end
    end
`endif

    sram_wait_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .value   (tmr_value),
        .expired (tmr_expired)
    );

    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_value  = '0;
        unique case (state)
            ST_IDLE: begin
                if (cpu_req) begin
                    if (addr_bad) begin
                        next_state = ST_DONE;
                    end else if (cpu_write) begin
                        next_state = ST_WR_SU;
                        tmr_load   = 1'b1;
                        tmr_value  = phase_load(WR_SETUP);
                    end else begin
                        next_state = ST_RD;
                        tmr_load   = 1'b1;
                        tmr_value  = phase_load(RD_WAIT);
                    end
                end
            end
            ST_RD: begin
                if (tmr_expired) next_state = ST_DONE;
            end
            ST_WR_SU: begin
                if (tmr_expired) begin
                    next_state = ST_WR_PW;
                    tmr_load   = 1'b1;
                    tmr_value  = phase_load(WR_PULSE);
                end
            end
            ST_WR_PW: begin
                if (tmr_expired) begin
                    next_state = ST_WR_HD;
                    tmr_load   = 1'b1;
                    tmr_value  = phase_load(WR_HOLD);
                end
            end
            ST_WR_HD: begin
                if (tmr_expired) next_state = ST_DONE;
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Strobes are decoded from the next state and registered, so they line up with the state.
    always_comb begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        unique case (next_state)
            ST_RD: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
            end
            ST_WR_SU, ST_WR_HD: begin
                ce_n_d  = 1'b0;
                dq_oe_d = 1'b1;
            end
            ST_WR_PW: begin
                ce_n_d  = 1'b0;
                dq_oe_d = 1'b1;
`ifdef SRAM_BRIDGE_BYTE_LANE_EN
                we_n_d  = ~(|be_next);
`else
                we_n_d  = 1'b0;
`endif
            end
            default: begin
                ce_n_d = 1'b1;
            end
        endcase
`ifdef SRAM_BRIDGE_BYTE_LANE_EN
        ub_n_d = ce_n_d | ~be_next[1];
        lb_n_d = ce_n_d | ~be_next[0];
`else
        ub_n_d = ce_n_d;
        lb_n_d = ce_n_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cpu_rdata   <= '0;
            cpu_ready   <= 1'b0;
            cpu_fault   <= 1'b0;
            cpu_busy    <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_ub_n   <= 1'b1;
            sram_lb_n   <= 1'b1;
        end else begin
            state      <= next_state;
            cpu_ready  <= (next_state == ST_DONE);
            // Only a rejected request goes straight from IDLE to DONE.
            cpu_fault  <= (state == ST_IDLE) && (next_state == ST_DONE);
            cpu_busy   <= (next_state != ST_IDLE);
            sram_dq_oe <= dq_oe_d;
            sram_ce_n  <= ce_n_d;
            sram_oe_n  <= oe_n_d;
            sram_we_n  <= we_n_d;
            sram_ub_n  <= ub_n_d;
            sram_lb_n  <= lb_n_d;
            if (accept && !addr_bad) begin
                sram_addr <= cpu_addr[ADDR_W-1:1];
                if (cpu_write) sram_dq_out <= cpu_wdata;
            end
            if ((state == ST_RD) && tmr_expired) begin
                cpu_rdata <= sram_dq_in;
            end
        end
    end

endmodule

// File: tb/tb_sram_bridge.sv
// Directed bench for sram_bridge: per-access strobe traces are recorded cycle by cycle
// and compared against hand-computed values for the default timing parameters.
module tb_sram_bridge;

    localparam int NC = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        cpu_write;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_fault;
    logic        cpu_busy;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_in;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_ub_n;
    logic        sram_lb_n;
`ifdef SRAM_BRIDGE_BYTE_LANE_EN
    logic [1:0]  cpu_be;
`endif

    int checks = 0;
    int errors = 0;

    logic        ce_a   [1:NC];
    logic        oe_a   [1:NC];
    logic        we_a   [1:NC];
    logic        dqoe_a [1:NC];
    logic        rdy_a  [1:NC];
    logic        flt_a  [1:NC];
    logic        busy_a [1:NC];
    logic        ub_a   [1:NC];
    logic        lb_a   [1:NC];
    logic [17:0] addr_a [1:NC];
    logic [15:0] dout_a [1:NC];
    logic [15:0] rd_a   [1:NC];
    int          first_rdy;

    sram_bridge dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_write   (cpu_write),
        .cpu_wdata   (cpu_wdata),
`ifdef SRAM_BRIDGE_BYTE_LANE_EN
        .cpu_be      (cpu_be),
`endif
        .cpu_rdata   (cpu_rdata),
        .cpu_ready   (cpu_ready),
        .cpu_fault   (cpu_fault),
        .cpu_busy    (cpu_busy),
        .sram_addr   (sram_addr),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_ce_n   (sram_ce_n),
        .sram_oe_n   (sram_oe_n),
        .sram_we_n   (sram_we_n),
        .sram_ub_n   (sram_ub_n),
        .sram_lb_n   (sram_lb_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Number of recorded cycles where the selected signal equals val.
    function automatic int cnt(input int sel, input logic val);
        int n = 0;
        for (int c = 1; c <= NC; c++) begin
            case (sel)
                0: n += int'(ce_a[c] === val);
                1: n += int'(oe_a[c] === val);
                2: n += int'(we_a[c] === val);
                3: n += int'(dqoe_a[c] === val);
                default: n += int'(rdy_a[c] === val);
            endcase
        end
        return n;
    endfunction

    function automatic int overlap_count();
        int n = 0;
        for (int c = 1; c <= NC; c++) begin
            if (oe_a[c] === 1'b0 && we_a[c] === 1'b0) n++;
            if (oe_a[c] === 1'b0 && dqoe_a[c] === 1'b1) n++;
        end
        return n;
    endfunction

    // Called at a negedge: issue one request, then record NC cycles. A second request
    // pulse is driven in cycle inj_cyc, and rst is driven high in cycle rst_cyc.
    task automatic run_access(input logic [31:0] addr, input logic wr, input logic [15:0] wd,
                              input int inj_cyc, input int rst_cyc);
        cpu_addr  = addr;
        cpu_write = wr;
        cpu_wdata = wd;
        cpu_req   = 1'b1;
        first_rdy = 0;
        @(negedge clk);
        for (int c = 1; c <= NC; c++) begin
            ce_a[c]   = sram_ce_n;
            oe_a[c]   = sram_oe_n;
            we_a[c]   = sram_we_n;
            dqoe_a[c] = sram_dq_oe;
            rdy_a[c]  = cpu_ready;
            flt_a[c]  = cpu_fault;
            busy_a[c] = cpu_busy;
            ub_a[c]   = sram_ub_n;
            lb_a[c]   = sram_lb_n;
            addr_a[c] = sram_addr;
            dout_a[c] = sram_dq_out;
            rd_a[c]   = cpu_rdata;
            if (cpu_ready === 1'b1 && first_rdy == 0) first_rdy = c;
            cpu_req = (c == inj_cyc);
            rst     = (c == rst_cyc);
            @(negedge clk);
        end
        cpu_req = 1'b0;
        rst     = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        cpu_req    = 1'b0;
        cpu_addr   = 32'h0;
        cpu_write  = 1'b0;
        cpu_wdata  = 16'h0;
        sram_dq_in = 16'h0;
`ifdef SRAM_BRIDGE_BYTE_LANE_EN
        cpu_be     = 2'b11;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_ce_n", 32'(sram_ce_n), 32'h1);
        check("rst_oe_n", 32'(sram_oe_n), 32'h1);
        check("rst_we_n", 32'(sram_we_n), 32'h1);
        check("rst_ub_lb", {30'h0, sram_ub_n, sram_lb_n}, 32'h3);
        check("rst_dq_oe", 32'(sram_dq_oe), 32'h0);
        check("rst_handshake", {29'h0, cpu_ready, cpu_fault, cpu_busy}, 32'h0);
        check("rst_rdata", 32'(cpu_rdata), 32'h0);
        check("rst_addr", 32'(sram_addr), 32'h0);
        check("rst_dq_out", 32'(sram_dq_out), 32'h0);

        // Read 0x10 returning 0xBEEF
        sram_dq_in = 16'hBEEF;
        run_access(32'h0000_0010, 1'b0, 16'h0, 0, 0);
        check("rd_oe_low_cycles", 32'(cnt(1, 1'b0)), 32'd2);
        check("rd_ce_low_cycles", 32'(cnt(0, 1'b0)), 32'd2);
        check("rd_addr", 32'(addr_a[1]), 32'h8);
        check("rd_ready_cycle", 32'(first_rdy), 32'd3);
        check("rd_ready_count", 32'(cnt(4, 1'b1)), 32'd1);
        check("rd_rdata", 32'(rd_a[3]), 32'hBEEF);
        check("rd_fault", 32'(flt_a[3]), 32'h0);
        check("rd_lanes_active", {30'h0, ub_a[1], lb_a[1]}, 32'h0);
        check("rd_lanes_done", {30'h0, ub_a[3], lb_a[3]}, 32'h3);
        check("rd_busy", {30'h0, busy_a[1], busy_a[4]}, 32'h2);
        check("rd_no_dq_oe", 32'(cnt(3, 1'b1)), 32'd0);

        // Write 0x1234 to the top word of the window
        sram_dq_in = 16'h5A5A;
        run_access(32'h0007_FFFE, 1'b1, 16'h1234, 0, 0);
        check("wr_addr", 32'(addr_a[1]), 32'h3FFFF);
        check("wr_we_low_cycles", 32'(cnt(2, 1'b0)), 32'd2);
        check("wr_we_low_position", {30'h0, we_a[2], we_a[3]}, 32'h0);
        check("wr_we_high_setup", 32'(we_a[1]), 32'h1);
        check("wr_dq_oe_cycles", 32'(cnt(3, 1'b1)), 32'd4);
        check("wr_ready_cycle", 32'(first_rdy), 32'd5);
        check("wr_ready_count", 32'(cnt(4, 1'b1)), 32'd1);
        check("wr_dq_out", 32'(dout_a[2]), 32'h1234);
        check("wr_oe_never_low", 32'(cnt(1, 1'b0)), 32'd0);
        check("wr_rdata_kept", 32'(rd_a[5]), 32'hBEEF);
        check("wr_done_idle", {30'h0, dqoe_a[5], ce_a[5]}, 32'h1);

        // Misaligned read
        run_access(32'h0000_0003, 1'b0, 16'h0, 0, 0);
        check("mis_ready_cycle", 32'(first_rdy), 32'd1);
        check("mis_fault", 32'(flt_a[1]), 32'h1);
        check("mis_ce_idle", 32'(cnt(0, 1'b0)), 32'd0);
        check("mis_ready_count", 32'(cnt(4, 1'b1)), 32'd1);
        check("mis_rdata_kept", 32'(rd_a[1]), 32'hBEEF);

        // Out-of-range read
        run_access(32'h0008_0000, 1'b0, 16'h0, 0, 0);
        check("oor_ready_cycle", 32'(first_rdy), 32'd1);
        check("oor_fault", 32'(flt_a[1]), 32'h1);
        check("oor_ce_idle", 32'(cnt(0, 1'b0)), 32'd0);
        check("oor_fault_cleared", 32'(flt_a[2]), 32'h0);

        // Out-of-range write must not drive the bus
        run_access(32'h0100_0000, 1'b1, 16'hDEAD, 0, 0);
        check("oor_wr_fault", 32'(flt_a[1]), 32'h1);
        check("oor_wr_no_drive", 32'(cnt(3, 1'b1)), 32'd0);
        check("oor_wr_dq_out_kept", 32'(dout_a[1]), 32'h1234);

        // Second request during the write pulse is ignored
        run_access(32'h0000_0100, 1'b1, 16'hCAFE, 2, 0);
        check("inj_ready_count", 32'(cnt(4, 1'b1)), 32'd1);
        check("inj_ready_cycle", 32'(first_rdy), 32'd5);
        check("inj_we_low_cycles", 32'(cnt(2, 1'b0)), 32'd2);
        check("inj_dq_oe_cycles", 32'(cnt(3, 1'b1)), 32'd4);
        check("inj_ce_low_cycles", 32'(cnt(0, 1'b0)), 32'd4);

        // Reset during the write pulse
        run_access(32'h0000_0200, 1'b1, 16'h7777, 0, 2);
        check("rstpw_we_low_before", 32'(we_a[2]), 32'h0);
        check("rstpw_strobes", {29'h0, we_a[3], ce_a[3], dqoe_a[3]}, 32'h6);
        check("rstpw_no_ready", 32'(cnt(4, 1'b1)), 32'd0);
        check("rstpw_busy", 32'(busy_a[3]), 32'h0);
        check("rstpw_rdata_reset", 32'(rd_a[3]), 32'h0);

        // Normal read after the reset
        sram_dq_in = 16'hA5C3;
        run_access(32'h0000_0020, 1'b0, 16'h0, 0, 0);
        check("post_rd_ready_cycle", 32'(first_rdy), 32'd3);
        check("post_rd_rdata", 32'(rd_a[3]), 32'hA5C3);
        check("post_rd_addr", 32'(addr_a[1]), 32'h10);
        check("post_rd_oe_low_cycles", 32'(cnt(1, 1'b0)), 32'd2);

`ifdef SRAM_BRIDGE_BYTE_LANE_EN
        cpu_be = 2'b10;
        run_access(32'h0000_0040, 1'b1, 16'hAB00, 0, 0);
        check("be10_lanes", {30'h0, ub_a[2], lb_a[2]}, 32'h1);
        check("be10_we_low_cycles", 32'(cnt(2, 1'b0)), 32'd2);
        cpu_be = 2'b00;
        run_access(32'h0000_0040, 1'b1, 16'hAB00, 0, 0);
        check("be00_no_we_pulse", 32'(cnt(2, 1'b0)), 32'd0);
        check("be00_ready_cycle", 32'(first_rdy), 32'd5);
        cpu_be = 2'b11;
`endif

        // Strobe exclusivity over the last recorded access
        check("overlap_last", 32'(overlap_count()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_bridge.md
Name: sram_bridge

Overview:
- Memory-side neighbour of the CPU core. Takes the core's 32-bit byte address and 16-bit word read/write requests and runs timed cycles on the external asynchronous 512 KB x16 SRAM.
- Returns read data to the core with a one-cycle `cpu_ready` handshake.
- Replaces the fixed single wait-state assumption with parameterised read/write timing.
- Flags misaligned or out-of-range accesses with `cpu_fault` instead of touching the SRAM.

Parameters:
- ADDR_W, 19: byte-address width of the SRAM window (0x00000000–0x0007FFFF).
- RD_WAIT, 2: cycles `oe_n` is held low before read data is captured (min 1).
- WR_SETUP, 1: cycles address/data are valid with `we_n` high before the write pulse (min 1).
- WR_PULSE, 2: cycles `we_n` is held low (min 1).
- WR_HOLD, 1: cycles data stays driven after `we_n` rises (min 1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  single-cycle request strobe; sampled only in IDLE
- cpu_addr  in  32  byte address
- cpu_write  in  1  1 = write, 0 = read
- cpu_wdata  in  16  write data
- cpu_rdata  out  16  read data, registered, valid while `cpu_ready` is high
- cpu_ready  out  1  one-cycle completion pulse
- cpu_fault  out  1  one-cycle pulse, coincident with `cpu_ready`, for a rejected access
- cpu_busy  out  1  high in every state except IDLE
- sram_addr  out  ADDR_W-1  word address = cpu_addr[ADDR_W-1:1]
- sram_dq_in  in  16  SRAM data bus input
- sram_dq_out  out  16  SRAM data bus output
- sram_dq_oe  out  1  tristate enable for `sram_dq_out`
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes
- sram_ub_n, sram_lb_n  out  1 each  active-low byte-lane enables

Behaviour:
- Reset values: FSM = IDLE; all `_n` strobes = 1; `sram_dq_oe` = 0; `cpu_ready`, `cpu_fault`, `cpu_busy` = 0; `cpu_rdata` = 0; `sram_addr` = 0; `sram_dq_out` = 0.
- Reset mid-cycle: on the edge where `rst` is sampled high, every strobe is deasserted and the in-flight access is dropped. No `cpu_ready` is issued for it.
- All SRAM outputs are registered; no combinational path from any input to any output.
- States: IDLE, RD, WR_SU, WR_PW, WR_HD, DONE. A single down-counter times RD, WR_SU, WR_PW and WR_HD.
- IDLE, `cpu_req` = 1:
  - Latch address, write flag and write data.
  - Fault if cpu_addr[0] = 1 or cpu_addr[31:ADDR_W] != 0: go to DONE with fault set and no strobe activity.
  - Otherwise go to RD or WR_SU, with `ce_n` = 0 and `sram_addr` valid from the next cycle.
- RD: `ce_n` = 0, `oe_n` = 0 for RD_WAIT cycles. On the final RD edge, `sram_dq_in` is captured into `cpu_rdata` and the FSM goes to DONE.
- Write sequence:
  - WR_SU: `dq_oe` = 1, `we_n` = 1, for WR_SETUP cycles.
  - WR_PW: `we_n` = 0 for WR_PULSE cycles.
  - WR_HD: `we_n` = 1, `dq_oe` = 1 for WR_HOLD cycles, then DONE.
- DONE: `cpu_ready` = 1 for exactly one cycle, all strobes high, `dq_oe` = 0; next state IDLE.
- Back-to-back: DONE provides one dead cycle (`ce_n` high) between accesses.
- Latency, counted from the `cpu_req` sampling edge to `cpu_ready` high:
  - read: RD_WAIT+1 cycles;
  - write: WR_SETUP+WR_PULSE+WR_HOLD+1 cycles;
  - fault: 1 cycle.
- `cpu_req` while `cpu_busy` = 1 is ignored, not queued. `cpu_rdata` holds its value until the next read completes; on a write or a fault, `cpu_rdata` is unchanged.
- `oe_n` and `we_n` are never low in the same cycle. `dq_oe` is never 1 while `oe_n` = 0.

Optional Feature:
- Macro: SRAM_BRIDGE_BYTE_LANE_EN.
- Defined: adds input `cpu_be` [1:0], latched with the request. `sram_ub_n` = ~be[1] and `sram_lb_n` = ~be[0] during the access; a write with `cpu_be` = 2'b00 completes with no `we_n` pulse.
- Undefined: the `cpu_be` port is absent; `ub_n` and `lb_n` are both 0 whenever `ce_n` = 0, and 1 otherwise.

Decomposition:
- Shared package `bexkat_mem_pkg` holds:
  - the FSM state enum;
  - SRAM_BASE = 32'h00000000 and SRAM_SIZE = 32'h00080000;
  - MONITOR_BASE = 32'hFF000000, for the future address decoder.
- One natural sub-module, `sram_wait_timer`: loadable down-counter with `load`, `value`, and an `expired` output, reused for all timed phases.

Test Plan:
- Reset, then read at 0x00000010 with `sram_dq_in` = 0xBEEF: `oe_n` low for exactly 2 cycles, `sram_addr` = 0x00008, `cpu_ready` 3 cycles after the request, `cpu_rdata` = 0xBEEF.
- Write 0x1234 to 0x0007FFFE: `sram_addr` = 0x3FFFF, `we_n` low exactly 2 cycles, `dq_oe` high 4 cycles, `cpu_ready` 5 cycles after the request.
- Read at 0x00000003 and read at 0x00080000: `cpu_fault` and `cpu_ready` high 1 cycle after the request, `ce_n` stays 1.
- Second `cpu_req` pulse during a write's WR_PW phase: ignored, only one `cpu_ready` is seen, the strobe sequence is unchanged.
- Assert `rst` during WR_PW: `we_n`, `ce_n` = 1 and `dq_oe` = 0 after the reset edge, no `cpu_ready`; a subsequent read works normally.
- With SRAM_BRIDGE_BYTE_LANE_EN, write with `cpu_be` = 2'b10: `ub_n` = 0, `lb_n` = 1 during the cycle; with `cpu_be` = 2'b00, no `we_n` pulse and `cpu_ready` is still issued.
